// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
package prog_loader_pkg;

  localparam int MEM_ADDR_WIDTH = 10;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_DEPTH      = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

  function automatic logic session_active(input state_t s);
    return accepts_bytes(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Collects four bytes, least significant first, into a 32-bit word.
module prog_loader_byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_o,
  output logic        word_ready
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d, word_next;

  always_comb begin
    word_next = word_q;
    if (byte_en) begin
      word_next[{idx_q, 3'b000} +: 8] = byte_in;
    end
    idx_d  = idx_q;
    word_d = word_next;
    if (clear) begin
      idx_d  = 2'd0;
      word_d = '0;
    end else if (byte_en) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  // Word including the byte arriving this cycle, so the writer can latch it on the same edge.
  assign word_o     = word_next;
  assign word_ready = byte_en && (idx_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, then little-endian words written to program memory.
module prog_loader #(
  parameter int ADDR_WIDTH = prog_loader_pkg::MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = prog_loader_pkg::MEM_DATA_WIDTH,
  parameter int MEM_DEPTH  = prog_loader_pkg::MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_rst_n
);
  import prog_loader_pkg::*;

  localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d, cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  in_ready_q, in_ready_d, mem_we_q, mem_we_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  xfer, asm_clear, asm_en, word_ready;
  logic [31:0]           asm_word;
  logic [15:0]           len_rx, cnt_inc;

  assign xfer      = in_valid && in_ready_q;
  assign len_rx    = {in_data, len_lo_q};
  assign cnt_inc   = cnt_q + 16'd1;
  assign asm_clear = xfer && (state_q == ST_LEN_HI);
  assign asm_en    = xfer && (state_q == ST_DATA);

  prog_loader_byte_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_in   (in_data),
    .word_o    (asm_word),
    .word_ready(word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_lo_d = in_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d  = len_rx;
          cnt_d  = '0;
          addr_d = '0;
          // Oversize images are rejected before any write, so the address never wraps.
          if (len_rx == 16'd0)                state_d = ST_DONE;
          else if ({1'b0, len_rx} > DEPTH_L)  state_d = ST_ERROR;
          else                                state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_ready) begin
          wdata_d = DATA_WIDTH'(asm_word);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they change on the same edge as it.
  always_comb begin
    in_ready_d  = accepts_bytes(state_d);
    busy_d      = session_active(state_d);
    mem_we_d    = (state_d == ST_WRITE);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERROR);
    cpu_rst_n_d = (state_d == ST_DONE);
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued by stimulus, checked by a write monitor.
module tb_prog_loader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, busy, done, err, cpu_rst_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  wr_seen = 0;
  bit  rand_gaps = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Write monitor: every mem_we must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_t e;
      wr_seen++;
      chk("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {22'd0, mem_addr}, {22'd0, e.addr});
        chk("write_data", mem_wdata, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (rand_gaps) begin
      int g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: got in_ready=0 for 100 cycles, expected acceptance of 0x%0h", b);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic wait_finish(output int c);
    int n = 0;
    c = 0;
    while (1) begin
      @(negedge clk);
      if (done || err) begin c = cyc; return; end
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL finish_timeout: got no done/err in 300 cycles, expected completion");
        return;
      end
    end
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d, input logic e, input logic c);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, c});
  endtask

  task automatic chk_all_zero(input string tag);
    chk_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t;

    #2 chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Two-word image, no back-pressure.
    wr_seen = 0;
    do_start();
    s = cyc;
    expect_wr(10'd0, 32'hDEADBEEF);
    expect_wr(10'd1, 32'h00100513);
    send_len(16'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h00100513);
    wait_finish(t);
    chk("t1_latency", t - s, 32'd12);
    chk_status("t1", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t1_writes", wr_seen, 32'd2);

    // Empty image; start in DONE drops cpu_rst_n on the start edge.
    wr_seen = 0;
    do_start();
    s = cyc;
    chk_status("t2_start", 1'b1, 1'b0, 1'b0, 1'b0);
    send_len(16'd0);
    wait_finish(t);
    chk("t2_latency", t - s, 32'd2);
    chk_status("t2", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_writes", wr_seen, 32'd0);

    // Oversize header N=1025, then restart clears err.
    wr_seen = 0;
    do_start();
    send_len(16'h0401);
    @(negedge clk);
    chk_status("t3", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_writes", wr_seen, 32'd0);
    do_start();
    chk_status("t3_restart", 1'b1, 1'b0, 1'b0, 1'b0);
    send_len(16'd0);
    wait_finish(t);
    chk_status("t3_end", 1'b0, 1'b1, 1'b0, 1'b1);

    // Same two-word image with in_valid gaps.
    wr_seen = 0;
    rand_gaps = 1'b1;
    do_start();
    expect_wr(10'd0, 32'hDEADBEEF);
    expect_wr(10'd1, 32'h00100513);
    send_len(16'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h00100513);
    wait_finish(t);
    rand_gaps = 1'b0;
    chk_status("t4", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4_writes", wr_seen, 32'd2);

    // Reset after the 6th byte of a two-word load, then a clean one-word reload.
    do_start();
    send_len(16'd2);
    send_word(32'hDEADBEEF);
    rst_n = 1'b0;
    #1 chk_all_zero("t5_async");
    @(posedge clk); #1 rst_n = 1'b1;
    wr_seen = 0;
    do_start();
    expect_wr(10'd0, 32'h11223344);
    send_len(16'd1);
    send_word(32'h11223344);
    wait_finish(t);
    chk_status("t5", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_writes", wr_seen, 32'd1);

    // start during DATA is ignored.
    wr_seen = 0;
    do_start();
    expect_wr(10'd0, 32'hDEADBEEF);
    expect_wr(10'd1, 32'h00100513);
    send_len(16'd2);
    send_byte(8'hEF);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk_status("t6_mid", 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_word(32'h00100513);
    wait_finish(t);
    chk_status("t6", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_writes", wr_seen, 32'd2);
    do_start();
    chk_status("t6_restart", 1'b1, 1'b0, 1'b0, 1'b0);
    send_len(16'd0);
    wait_finish(t);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
